// File: rtl/demux_sel_sequencer_if.sv
// Control/data bundle between a sequencer user and the demux sel sequencer.
//   start, stop, ch_en[3:0], data_in : user -> sequencer
//   data_out, sel[1:0], busy, frame_done, frame_cnt[FRAME_W-1:0] : sequencer -> user/demux
`timescale 1ns/1ps
interface demux_sel_sequencer_if #(
  parameter int unsigned FRAME_W = 8
);
  logic               start;
  logic               stop;
  logic [3:0]         ch_en;
  logic               data_in;
  logic               data_out;
  logic [1:0]         sel;
  logic               busy;
  logic               frame_done;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    output start, stop, ch_en, data_in,
    input  data_out, sel, busy, frame_done, frame_cnt
  );

  modport slave (
    input  start, stop, ch_en, data_in,
    output data_out, sel, busy, frame_done, frame_cnt
  );
endinterface

// File: rtl/demux_sel_sequencer.sv
// Round-robin sel/data driver for a 4-way 1-bit demux. Each enabled channel is
// held for DWELL cycles; a wrap back to the lowest enabled channel is a frame.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side of demux_sel_sequencer_if (start/stop/ch_en/data_in in,
//              registered data_out/sel/busy/frame_done/frame_cnt out)
`timescale 1ns/1ps
module demux_sel_sequencer #(
  parameter int unsigned DWELL   = 4,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned FRAME_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  demux_sel_sequencer_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  state_t             state_q;
  logic [1:0]         sel_q;
  logic               data_out_q;
  logic               busy_q;
  logic               frame_done_q;
  logic [FRAME_W-1:0] frame_cnt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               stop_pend_q;

  logic [1:0]         lowest_ch;
  logic [1:0]         next_up_ch;
  logic               has_up;

  // Lowest enabled channel, and nearest enabled channel above the current sel.
  // Scanning downward leaves the smallest match in each result.
  always_comb begin
    lowest_ch  = 2'd0;
    next_up_ch = 2'd0;
    has_up     = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.ch_en[i]) begin
        lowest_ch = 2'(i);
        if (2'(i) > sel_q) begin
          next_up_ch = 2'(i);
          has_up     = 1'b1;
        end
      end
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= 2'd0;
      data_out_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      cnt_q        <= '0;
      stop_pend_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sel_q        <= 2'd0;
          data_out_q   <= 1'b0;
          busy_q       <= 1'b0;
          frame_done_q <= 1'b0;
          cnt_q        <= '0;
          stop_pend_q  <= 1'b0;
          // stop beats start; an empty mask is not a valid launch
          if (bus.start && !bus.stop && (bus.ch_en != 4'd0)) begin
            state_q <= RUN;
            sel_q   <= lowest_ch;
            busy_q  <= 1'b1;
          end
        end

        RUN: begin
          data_out_q   <= bus.data_in;
          frame_done_q <= 1'b0;
          if (bus.stop) begin
            stop_pend_q <= 1'b1;
          end
          if (cnt_q == DWELL_LAST) begin
            cnt_q <= '0;
            if (bus.ch_en == 4'd0) begin
              // nothing left to serve: leave without counting a frame
              state_q     <= IDLE;
              sel_q       <= 2'd0;
              data_out_q  <= 1'b0;
              busy_q      <= 1'b0;
              stop_pend_q <= 1'b0;
            end else begin
              if (has_up) begin
                sel_q <= next_up_ch;
              end else begin
                sel_q        <= lowest_ch;
                frame_done_q <= 1'b1;
                frame_cnt_q  <= frame_cnt_q + FRAME_W'(1);
              end
              // a stop seen during this dwell (including its last cycle) ends here;
              // a coincident wrap still reports its frame
              if (stop_pend_q || bus.stop) begin
                state_q     <= IDLE;
                sel_q       <= 2'd0;
                data_out_q  <= 1'b0;
                busy_q      <= 1'b0;
                stop_pend_q <= 1'b0;
              end
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.sel        = sel_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Self-checking bench for demux_sel_sequencer: DUT A (DWELL=4, FRAME_W=8) and
// DUT B (DWELL=1, FRAME_W=2). Expected outputs are queued as stimulus is driven
// and popped once the following clock edge has produced the DUT response.
`timescale 1ns/1ps
module tb_demux_sel_sequencer;

  typedef struct packed {
    logic [1:0] sel;
    logic       busy;
    logic       dout;
    logic       fd;
    logic [7:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  demux_sel_sequencer_if #(.FRAME_W(8)) bus_a ();
  demux_sel_sequencer_if #(.FRAME_W(2)) bus_b ();

  demux_sel_sequencer #(.DWELL(4), .CNT_W(4), .FRAME_W(8)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  demux_sel_sequencer #(.DWELL(1), .CNT_W(4), .FRAME_W(2)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  function automatic obs_t mk(input logic [1:0] sel, input logic busy, input logic dout,
                              input logic fd, input logic [7:0] cnt);
    obs_t o;
    o.sel = sel; o.busy = busy; o.dout = dout; o.fd = fd; o.cnt = cnt;
    return o;
  endfunction

  function automatic obs_t obs_a();
    return mk(bus_a.sel, bus_a.busy, bus_a.data_out, bus_a.frame_done, bus_a.frame_cnt);
  endfunction

  function automatic obs_t obs_b();
    return mk(bus_b.sel, bus_b.busy, bus_b.data_out, bus_b.frame_done, 8'(bus_b.frame_cnt));
  endfunction

  function automatic string ostr(input obs_t o);
    return $sformatf("sel=%0d busy=%0b dout=%0b fd=%0b cnt=%0d", o.sel, o.busy, o.dout, o.fd, o.cnt);
  endfunction

  task automatic idle_inputs();
    bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.ch_en = 4'd0; bus_a.data_in = 1'b0;
    bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.ch_en = 4'd0; bus_b.data_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t a;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    a = obs_a(); checks++;
    if (a !== mk(2'd0, 1'b0, 1'b0, 1'b0, 8'd0)) begin
      errors++; $display("FAIL reset_a got %s want all zero", ostr(a));
    end
    a = obs_b(); checks++;
    if (a !== mk(2'd0, 1'b0, 1'b0, 1'b0, 8'd0)) begin
      errors++; $display("FAIL reset_b got %s want all zero", ostr(a));
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_sweep();
    obs_t e, a; logic d;
    do_reset();
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      d = 1'($urandom);
      bus_a.data_in = d; bus_a.start = (n == 1); bus_a.ch_en = 4'b1111;
      exp_q.push_back(mk(2'(((n - 1) / 4) % 4), 1'b1, (n == 1) ? 1'b0 : d,
                         (n > 1) && ((n - 1) % 16 == 0), 8'((n - 1) / 16)));
      @(posedge clk); #1;
      e = exp_q.pop_front(); a = obs_a(); checks++;
      if (a !== e) begin
        errors++; $display("FAIL full_sweep n=%0d got %s want %s", n, ostr(a), ostr(e));
      end
    end
  endtask

  task automatic test_alternate();
    obs_t e, a;
    do_reset();
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      bus_a.data_in = 1'b1; bus_a.start = (n == 1); bus_a.ch_en = 4'b1010;
      exp_q.push_back(mk((((n - 1) / 4) % 2 == 1) ? 2'd3 : 2'd1, 1'b1, n >= 2,
                         (n > 1) && ((n - 1) % 8 == 0), 8'((n - 1) / 8)));
      @(posedge clk); #1;
      e = exp_q.pop_front(); a = obs_a(); checks++;
      if (a !== e) begin
        errors++; $display("FAIL alternate n=%0d got %s want %s", n, ostr(a), ostr(e));
      end
    end
  endtask

  task automatic test_stop();
    obs_t e, a; logic d;
    do_reset();
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      d = 1'($urandom);
      bus_a.data_in = d;
      bus_a.start   = (n == 1) || (n == 15);
      bus_a.stop    = (n == 11);
      bus_a.ch_en   = (n < 15) ? 4'b1111 : 4'b0110;
      if (n <= 12)
        e = mk(2'((n - 1) / 4), 1'b1, (n == 1) ? 1'b0 : d, 1'b0, 8'd0);
      else if (n <= 14)
        e = mk(2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      else
        e = mk(2'd1, 1'b1, (n == 15) ? 1'b0 : d, 1'b0, 8'd0);
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front(); a = obs_a(); checks++;
      if (a !== e) begin
        errors++; $display("FAIL stop n=%0d got %s want %s", n, ostr(a), ostr(e));
      end
    end
    bus_a.stop = 1'b0;
  endtask

  task automatic test_idle_ignore();
    obs_t e, a;
    do_reset();
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      bus_a.data_in = 1'b1;
      bus_a.start   = (n <= 2);
      bus_a.stop    = (n == 1);
      bus_a.ch_en   = (n == 2) ? 4'b0000 : 4'b1111;
      exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 8'd0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); a = obs_a(); checks++;
      if (a !== e) begin
        errors++; $display("FAIL idle_ignore n=%0d got %s want %s", n, ostr(a), ostr(e));
      end
    end
    bus_a.start = 1'b0; bus_a.stop = 1'b0;
  endtask

  task automatic test_mask_zero();
    obs_t e, a; logic d;
    do_reset();
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      d = 1'($urandom);
      bus_a.data_in = d; bus_a.start = (n == 1);
      bus_a.ch_en   = (n < 3) ? 4'b0011 : 4'b0000;
      if (n <= 4) e = mk(2'd0, 1'b1, (n == 1) ? 1'b0 : d, 1'b0, 8'd0);
      else        e = mk(2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front(); a = obs_a(); checks++;
      if (a !== e) begin
        errors++; $display("FAIL mask_zero n=%0d got %s want %s", n, ostr(a), ostr(e));
      end
    end
  endtask

  task automatic test_mask_change();
    obs_t e, a; logic d;
    do_reset();
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      d = 1'($urandom);
      bus_a.data_in = d; bus_a.start = (n == 1);
      bus_a.ch_en   = (n < 6) ? 4'b1111 : 4'b0001;
      if (n <= 4)      e = mk(2'd0, 1'b1, (n == 1) ? 1'b0 : d, 1'b0, 8'd0);
      else if (n <= 8) e = mk(2'd1, 1'b1, d, 1'b0, 8'd0);
      else             e = mk(2'd0, 1'b1, d, (n - 9) % 4 == 0, 8'((n - 9) / 4 + 1));
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front(); a = obs_a(); checks++;
      if (a !== e) begin
        errors++; $display("FAIL mask_change n=%0d got %s want %s", n, ostr(a), ostr(e));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    obs_t e, a; logic d;
    do_reset();
    for (int n = 1; n <= 28; n++) begin
      @(negedge clk);
      d = 1'($urandom);
      bus_a.data_in = d; bus_a.start = (n == 1); bus_a.ch_en = 4'b1111;
      rst = (n == 27);
      if (n <= 26)
        e = mk(2'(((n - 1) / 4) % 4), 1'b1, (n == 1) ? 1'b0 : d,
               (n > 1) && ((n - 1) % 16 == 0), 8'((n - 1) / 16));
      else
        e = mk(2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front(); a = obs_a(); checks++;
      if (a !== e) begin
        errors++; $display("FAIL reset_mid_run n=%0d got %s want %s", n, ostr(a), ostr(e));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_dwell1_wrap();
    obs_t e, a; logic d;
    do_reset();
    for (int n = 1; n <= 21; n++) begin
      @(negedge clk);
      d = 1'($urandom);
      bus_b.data_in = d; bus_b.start = (n == 1); bus_b.ch_en = 4'b1111;
      exp_q.push_back(mk(2'((n - 1) % 4), 1'b1, (n == 1) ? 1'b0 : d,
                         (n > 1) && ((n - 1) % 4 == 0), 8'(((n - 1) / 4) % 4)));
      @(posedge clk); #1;
      e = exp_q.pop_front(); a = obs_b(); checks++;
      if (a !== e) begin
        errors++; $display("FAIL dwell1_wrap n=%0d got %s want %s", n, ostr(a), ostr(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_alternate();
    test_stop();
    test_idle_ignore();
    test_mask_zero();
    test_mask_change();
    test_reset_mid_run();
    test_dwell1_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/demux_sel_sequencer.md
Name: demux_sel_sequencer

Overview:
- Upstream control stage for the 4-way 1-bit demultiplexer (data/sel → out0..out3).
- Drives the demux `sel` and `data` inputs so a single serial input is time-sliced round-robin across the enabled output channels.
- Each channel holds for a programmable dwell period; a completed sweep of all enabled channels is a frame, which the block counts and flags.

Parameters:
- DWELL, 4, cycles each channel is selected before advancing; legal range 1..2^CNT_W.
- CNT_W, 4, width of the internal dwell counter.
- FRAME_W, 8, width of the frame counter output.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin sequencing; sampled in IDLE only.
- stop  input  1  request stop; honoured at the end of the current dwell.
- ch_en  input  4  per-channel enable mask; bit i enables demux out i.
- data_in  input  1  serial data to distribute.
- data_out  output  1  to demux data input; registered.
- sel  output  2  to demux sel input; registered.
- busy  output  1  high while in RUN.
- frame_done  output  1  one-cycle pulse at each frame completion.
- frame_cnt  output  FRAME_W  completed frames since reset; wraps.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; sel=0, data_out=0, busy=0, frame_done=0, frame_cnt=0.
  - Dwell counter cleared and stop_pending cleared.
  - rst mid-RUN aborts immediately, with the same values on the next edge.
- States: IDLE, RUN.
- IDLE:
  - Outputs are sel=0, data_out=0, busy=0.
  - start=1 with stop=0 and ch_en≠0 → RUN on the next edge.
  - On that entry, sel = lowest set bit of ch_en and the dwell counter = 0.
  - start=1 with ch_en=0 is ignored.
  - start and stop asserted together → stop wins; stay IDLE.
- RUN:
  - Every edge: data_out <= data_in, so latency is 1 cycle and data_out stays aligned with the registered sel.
  - busy=1.
  - Dwell counter increments each cycle.
  - When the counter reaches DWELL-1 (the dwell boundary), it resets to 0 and the next-channel decision is made.
- Next-channel decision at each dwell boundary, using ch_en sampled that cycle:
  - Next sel = next set bit of ch_en above the current sel, searching upward.
  - If there is none, wrap to the lowest set bit. A wrap completes a frame: frame_done=1 for exactly that one cycle and frame_cnt increments modulo 2^FRAME_W.
  - With exactly one channel enabled, sel is unchanged and frame_done pulses every DWELL cycles.
  - ch_en changes between boundaries have no effect until the next boundary.
  - If ch_en=0 at a boundary → IDLE, same as stop, with no frame_done.
- Stop handling:
  - stop=1 in RUN sets stop_pending.
  - At the next dwell boundary → IDLE: sel=0, data_out=0, busy=0, and stop_pending is cleared.
  - If that boundary is also a wrap, frame_done still pulses and frame_cnt still increments on that same edge.
- start is ignored in RUN.
- DWELL=1: sel advances every cycle.
- Counter widths: the dwell counter does not overflow for legal DWELL; frame_cnt wraps from 2^FRAME_W-1 to 0 silently.

Test Plan:
- Reset, then start with ch_en=4'b1111, DWELL=4 → sel follows 0,0,0,0,1,1,1,1,2…,3…,0; frame_done pulses on the edge where sel returns 3→0; frame_cnt=1 after 16 cycles.
- Hold data_in=1, ch_en=4'b1010 → sel alternates 1 (4 cycles), 3 (4 cycles); data_out=1 from the cycle after RUN entry; frame_done every 8 cycles.
- Assert stop for one cycle at dwell count 1 of channel 2 → stays on sel=2 until count 3, then IDLE: busy=0, sel=0, data_out=0; a later start restarts at the lowest enabled channel.
- Assert start and stop together in IDLE → remains IDLE. start with ch_en=0 → remains IDLE, busy=0.
- Mid-RUN, change ch_en from 4'b1111 to 4'b0001 while sel=1 → sel=1 finishes its dwell, then goes to 0 with frame_done=1; thereafter sel stays 0 and frame_done pulses every 4 cycles.
- Pulse rst mid-dwell on sel=2 → next edge gives sel=0, busy=0, frame_cnt=0, frame_done=0. Separately, with FRAME_W=2, run 5 frames → frame_cnt reads 1.
